kanade_lsu: RTL and testbench
=============================

# kanade_lsu

Parametrised load/store unit that sits between the CPU memory-access stage and the single-port synchronous RAM (one-cycle read latency, byte enables). It takes one request at a time through a valid/ready handshake and derives the word address, byte enables and lane-shifted write data. On reads it extracts and sign- or zero-extends the result. Generalised to 32- or 64-bit data. Optionally splits an access that crosses a word boundary into two RAM cycles, or rejects it with an error.

## Interface
- XLEN, 32: data/bus width, 32 or 64; NB = XLEN/8 bytes per RAM word.
- ADDR_W, 32: byte-address width.
- ALLOW_MISALIGN, 1: 1 = split boundary-crossing accesses; 0 = misaligned access returns error.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; state to IDLE at the next clk edge.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  3  access mode, see package constants.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal mode or forbidden misalignment.
- mem_addr  out  ADDR_W-log2(NB)  RAM word address.
- mem_wren  out  1  RAM write strobe.
- mem_byteen  out  NB  byte enables; all ones on reads.
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_rdata  in  XLEN  RAM data; valid the cycle after its address was presented.

## Operation
- Modes: BYTE 0, BYTE_SIGN 1, HWORD 2, HWORD_SIGN 3, WORD 4, WORD_SIGN 5, DWORD 6.
- Access size is 1, 2, 4 or 8 bytes. Mode 5 or 6 with XLEN=32, mode 7, or a SIGN mode on a store is illegal.
- Request is accepted on a clk edge with req_valid & req_ready. Mode, address, data and write flag are captured.
- Byte offset is off = addr mod NB. A crossing access is one where off + size > NB.
- With ALLOW_MISALIGN=0, the error condition is addr mod size != 0 (size ≤ NB); it is checked at acceptance, together with the illegal-mode check.
- States and transitions:
  - IDLE → ERR on an error condition.
  - IDLE → ACC0 on any other acceptance.
  - ACC0 → ACC1 if the access crosses a word boundary.
  - ACC0 → FIN for an aligned load.
  - ACC0 → RESP for an aligned store.
  - ACC1 → FIN for a load.
  - ACC1 → RESP for a store.
  - FIN → RESP.
  - RESP → IDLE.
  - ERR → IDLE.
- Store formatting: over a 2·NB-byte window, data is shifted left by off·8 and byte enables are ((1<<size)−1)<<off. ACC0 presents the low half at word addr/NB; ACC1 presents the high half at word+1. mem_wren is asserted in ACC0, and in ACC1 only if its enable half is nonzero.
- Load: mem_rdata is captured as the low word in ACC1 (crossing access) or FIN (aligned access), and as the high word in FIN (crossing access).
- Load extraction: ({hi,lo} >> off·8) is masked to size bytes, then sign-extended for SIGN modes and zero-extended otherwise. The result is registered into resp_rdata on entry to RESP.
- mem_* outputs are combinational decodes of state plus captured registers. Outside ACC0/ACC1, mem_wren = 0 and mem_byteen = all ones.
- Reset in any state: IDLE at the next edge, and mem_wren is low from that edge. A crossing store reset after ACC0 leaves its first half committed; this is defined behaviour.

## Timing
- Reset values: req_ready 1 (IDLE), resp_valid 0, resp_rdata 0, resp_err 0, mem_wren 0, mem_byteen all ones, mem_addr 0, mem_wdata 0.
- Acceptance edge is cycle 0. resp_valid is high in:
  - cycle 3 for an aligned load;
  - cycle 4 for a crossing load;
  - cycle 2 for an aligned store;
  - cycle 3 for a crossing store;
  - cycle 1 for an error.
- req_ready returns the cycle after resp_valid, so the maximum throughput is one access per 3–5 cycles.
- req_valid while busy is ignored; the requester holds it.

## Structure
- Shared package kanade_mem_pkg holds:
  - the MEM_MODE_* constants;
  - a mode→size function;
  - an is_signed function.
  The CPU decoder uses the same package.
- Sub-module kanade_lsu_align is purely combinational. It takes mode, offset, wdata and {hi,lo} and produces byte enables, the shifted write window and the extended read result.
- The FSM and capture registers live in kanade_lsu.

## Test plan
- XLEN=32, aligned load WORD at 0x10, RAM word 4 = 0xDEADBEEF → mem_addr 4 in cycle 1; resp_valid in cycle 3 with rdata 0xDEADBEEF, err 0.
- Load at 0x13, word 4 = 0x80FF0000: BYTE_SIGN → 0xFFFFFF80; BYTE → 0x00000080.
- ALLOW_MISALIGN=1, load WORD at 0x0E, word 3 = 0x44332211, word 4 = 0x88776655:
  - mem_addr is 3 in cycle 1 and 4 in cycle 2;
  - resp_valid in cycle 4 with rdata 0x66554433.
- Store HWORD 0xABCD at 0x07:
  - ACC0: mem_addr 1, byteen 4'b1000, wdata 0xCD000000;
  - ACC1: mem_addr 2, byteen 4'b0001, wdata 0x000000AB;
  - resp_valid in cycle 3.
- ALLOW_MISALIGN=0, load WORD at 0x02 → resp_valid and resp_err in cycle 1, no mem_wren. XLEN=32 with mode DWORD → same error response.
- XLEN=64, load DWORD at 0x8 with word 1 = 0x0123456789ABCDEF → rdata 0x0123456789ABCDEF. Reset asserted during ACC1 of a crossing store → IDLE and req_ready 1 next cycle, mem_wren 0, no resp_valid.

Source files
------------

// File: rtl/kanade_mem_pkg.sv
// Memory-access modes and size/sign helpers shared by the CPU decoder and the LSU.
package kanade_mem_pkg;

  localparam logic [2:0] MEM_MODE_BYTE       = 3'd0;
  localparam logic [2:0] MEM_MODE_BYTE_SIGN  = 3'd1;
  localparam logic [2:0] MEM_MODE_HWORD      = 3'd2;
  localparam logic [2:0] MEM_MODE_HWORD_SIGN = 3'd3;
  localparam logic [2:0] MEM_MODE_WORD       = 3'd4;
  localparam logic [2:0] MEM_MODE_WORD_SIGN  = 3'd5;
  localparam logic [2:0] MEM_MODE_DWORD      = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_FIN,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  // Access size in bytes; 0 marks the undefined mode.
  function automatic logic [3:0] mode_size(input logic [2:0] mode);
    case (mode)
      MEM_MODE_BYTE,  MEM_MODE_BYTE_SIGN:  mode_size = 4'd1;
      MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN: mode_size = 4'd2;
      MEM_MODE_WORD,  MEM_MODE_WORD_SIGN:  mode_size = 4'd4;
      MEM_MODE_DWORD:                      mode_size = 4'd8;
      default:                             mode_size = 4'd0;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] mode);
    return (mode == MEM_MODE_BYTE_SIGN) || (mode == MEM_MODE_HWORD_SIGN) ||
           (mode == MEM_MODE_WORD_SIGN);
  endfunction

endpackage

// File: rtl/kanade_lsu_align.sv
// Lane alignment: store byte-enable/data window and load extraction over a two-word window.
module kanade_lsu_align
  import kanade_mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                mode,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [XLEN-1:0]           wdata,
  input  logic [2*XLEN-1:0]         rwin,
  output logic [XLEN/4-1:0]         byteen_win,
  output logic [2*XLEN-1:0]         wdata_win,
  output logic [XLEN-1:0]           rdata_ext
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned BE_W = 2 * NB;

  logic [3:0]        size;
  logic [BE_W-1:0]   be_mask;
  logic [2*XLEN-1:0] rshift;
  logic              sign_bit;

  always_comb begin
    size       = mode_size(mode);
    be_mask    = '0;
    rdata_ext  = '0;
    sign_bit   = 1'b0;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (i < int'(size)) be_mask[i] = 1'b1;
    end
    byteen_win = be_mask << off;
    wdata_win  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rshift     = rwin >> {off, 3'b000};
    // Top byte of the access supplies the sign for SIGN modes.
    for (int i = 0; i < int'(NB); i++) begin
      if (i == int'(size) - 1) sign_bit = is_signed(mode) & rshift[8*i+7];
    end
    for (int i = 0; i < int'(NB); i++) begin
      rdata_ext[8*i +: 8] = (i < int'(size)) ? rshift[8*i +: 8] : {8{sign_bit}};
    end
  end

endmodule

// File: rtl/kanade_lsu.sv
// Load/store unit: one request at a time, optional split of word-crossing accesses.
module kanade_lsu
  import kanade_mem_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [2:0]                        req_mode,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [XLEN-1:0]                   req_wdata,
  output logic                              resp_valid,
  output logic [XLEN-1:0]                   resp_rdata,
  output logic                              resp_err,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0]  mem_addr,
  output logic                              mem_wren,
  output logic [XLEN/8-1:0]                 mem_byteen,
  output logic [XLEN-1:0]                   mem_wdata,
  input  logic [XLEN-1:0]                   mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned WA_W  = ADDR_W - OFF_W;

  lsu_state_t       state_q, state_d;
  logic             write_q, write_d;
  logic [2:0]       mode_q, mode_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [WA_W-1:0]  word_q, word_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;

  logic [2:0]       low_mask_c;
  logic             req_err_c;
  logic             cross_c;
  logic [2*XLEN-1:0] rwin_c;
  logic [2*NB-1:0]  byteen_win;
  logic [2*XLEN-1:0] wdata_win;
  logic [XLEN-1:0]  rdata_ext;

  kanade_lsu_align #(.XLEN(XLEN)) u_align (
    .mode       (mode_q),
    .off        (off_q),
    .wdata      (wdata_q),
    .rwin       (rwin_c),
    .byteen_win (byteen_win),
    .wdata_win  (wdata_win),
    .rdata_ext  (rdata_ext)
  );

  // Acceptance-time legality; size-1 in 3 bits doubles as the alignment mask (8 -> 7).
  always_comb begin
    low_mask_c = 3'(mode_size(req_mode)) - 3'd1;
    req_err_c  = (req_mode == 3'd7) ||
                 ((XLEN == 32) && ((req_mode == MEM_MODE_WORD_SIGN) ||
                                   (req_mode == MEM_MODE_DWORD))) ||
                 (req_write && is_signed(req_mode)) ||
                 (!ALLOW_MISALIGN && ((req_addr[2:0] & low_mask_c) != 3'd0));
    cross_c    = (int'(off_q) + int'(mode_size(mode_q))) > int'(NB);
    rwin_c     = cross_c ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    mode_d       = mode_q;
    off_d        = off_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          mode_d  = req_mode;
          off_d   = req_addr[OFF_W-1:0];
          word_d  = req_addr[ADDR_W-1:OFF_W];
          wdata_d = req_wdata;
          if (req_err_c) begin
            state_d      = ST_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = ST_ACC0;
          end
        end
      end
      ST_ACC0: begin
        if (cross_c) begin
          state_d = ST_ACC1;
        end else if (write_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_ACC1: begin
        lo_d = mem_rdata;
        if (write_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = rdata_ext;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      mode_q       <= '0;
      off_q        <= '0;
      word_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      mode_q       <= mode_d;
      off_q        <= off_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // RAM port decode: low window half in ACC0, high half at the next word in ACC1.
  always_comb begin
    mem_addr   = '0;
    mem_wren   = 1'b0;
    mem_byteen = '1;
    mem_wdata  = '0;
    case (state_q)
      ST_ACC0: begin
        mem_addr = word_q;
        if (write_q) begin
          mem_wren   = 1'b1;
          mem_byteen = byteen_win[NB-1:0];
          mem_wdata  = wdata_win[XLEN-1:0];
        end
      end
      ST_ACC1: begin
        mem_addr = word_q + WA_W'(1);
        if (write_q) begin
          mem_wren   = |byteen_win[2*NB-1:NB];
          mem_byteen = byteen_win[2*NB-1:NB];
          mem_wdata  = wdata_win[2*XLEN-1:XLEN];
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_kanade_lsu.sv
// Bench for kanade_lsu: three configurations against a byte-level memory model.
module tb_kanade_lsu;
  import kanade_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  // a: XLEN 32 split; b: XLEN 32 strict alignment; c: XLEN 64 split
  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_wren;
  logic [31:0] a_resp_rdata, a_mem_wdata, a_mem_rdata;
  logic [29:0] a_mem_addr;
  logic [3:0]  a_mem_byteen;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_wren;
  logic [31:0] b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic [29:0] b_mem_addr;
  logic [3:0]  b_mem_byteen;
  logic        c_req_ready, c_resp_valid, c_resp_err, c_mem_wren;
  logic [63:0] c_resp_rdata, c_mem_wdata, c_mem_rdata;
  logic [28:0] c_mem_addr;
  logic [7:0]  c_mem_byteen;

  kanade_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .mem_addr(a_mem_addr), .mem_wren(a_mem_wren),
    .mem_byteen(a_mem_byteen), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  kanade_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mem_addr(b_mem_addr), .mem_wren(b_mem_wren),
    .mem_byteen(b_mem_byteen), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  kanade_lsu #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(c_req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata),
    .resp_err(c_resp_err), .mem_addr(c_mem_addr), .mem_wren(c_mem_wren),
    .mem_byteen(c_mem_byteen), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata));

  // Synchronous RAMs over a 256-byte window; poke port preloads all three.
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] ram_c [256];
  logic       poke_en = 1'b0;
  logic [7:0] poke_adr, poke_val;

  always @(posedge clk) begin
    if (poke_en) ram_a[poke_adr] <= poke_val;
    for (int k = 0; k < 4; k++) begin
      if (a_mem_wren && a_mem_byteen[k]) ram_a[int'(a_mem_addr[5:0])*4+k] <= a_mem_wdata[8*k +: 8];
      a_mem_rdata[8*k +: 8] <= ram_a[int'(a_mem_addr[5:0])*4+k];
    end
  end
  always @(posedge clk) begin
    if (poke_en) ram_b[poke_adr] <= poke_val;
    for (int k = 0; k < 4; k++) begin
      if (b_mem_wren && b_mem_byteen[k]) ram_b[int'(b_mem_addr[5:0])*4+k] <= b_mem_wdata[8*k +: 8];
      b_mem_rdata[8*k +: 8] <= ram_b[int'(b_mem_addr[5:0])*4+k];
    end
  end
  always @(posedge clk) begin
    if (poke_en) ram_c[poke_adr] <= poke_val;
    for (int k = 0; k < 8; k++) begin
      if (c_mem_wren && c_mem_byteen[k]) ram_c[int'(c_mem_addr[4:0])*8+k] <= c_mem_wdata[8*k +: 8];
      c_mem_rdata[8*k +: 8] <= ram_c[int'(c_mem_addr[4:0])*8+k];
    end
  end

  logic [7:0]  refm [3][256];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat [3];
  int          nresp [3];
  logic [63:0] rd [3];
  logic        er [3], wr_seen [3], rdy_after [3];
  logic [29:0] a_addr_c [1:6];
  logic [3:0]  a_be_c [1:6];
  logic [31:0] a_wd_c [1:6];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic poke(input int adr, input logic [7:0] val);
    for (int d = 0; d < 3; d++) refm[d][adr & 255] = val;
    poke_en  = 1'b1;
    poke_adr = 8'(adr);
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic poke_bytes(input int adr, input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) poke(adr + i, val[8*i +: 8]);
  endtask

  // Issue one request, watch six cycles, then compare every DUT with the model.
  task automatic do_req(input logic w, input logic [2:0] m, input logic [31:0] ad,
                        input logic [63:0] wd);
    logic [2:0] vv, ww, rr, ee;
    req_write = w; req_mode = m; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; nresp[d] = 0; rd[d] = '0; er[d] = 1'b0; wr_seen[d] = 1'b0; rdy_after[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      vv = {c_resp_valid, b_resp_valid, a_resp_valid};
      ww = {c_mem_wren, b_mem_wren, a_mem_wren};
      rr = {c_req_ready, b_req_ready, a_req_ready};
      ee = {c_resp_err, b_resp_err, a_resp_err};
      for (int d = 0; d < 3; d++) begin
        if (lat[d] != 0 && k == lat[d] + 1) rdy_after[d] = rr[d];
        if (ww[d]) wr_seen[d] = 1'b1;
        if (vv[d]) begin
          nresp[d]++;
          if (lat[d] == 0) begin
            lat[d] = k;
            er[d]  = ee[d];
            rd[d]  = (d == 0) ? {32'd0, a_resp_rdata} :
                     (d == 1) ? {32'd0, b_resp_rdata} : c_resp_rdata;
          end
        end
      end
      a_addr_c[k] = a_mem_addr; a_be_c[k] = a_mem_byteen; a_wd_c[k] = a_mem_wdata;
      if (k < 6) @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      int nb, size, off, elat;
      logic illegal, err, crossing;
      logic [63:0] v;
      nb   = (d == 2) ? 8 : 4;
      size = (m <= 3'd1) ? 1 : (m <= 3'd3) ? 2 : (m <= 3'd5) ? 4 : (m == 3'd6) ? 8 : 0;
      illegal = (m == 3'd7) || (d != 2 && m >= 3'd5) || (w && m[0]);
      err  = illegal || (d == 1 && (int'(ad) % size) != 0);
      off  = int'(ad) % nb;
      crossing = (off + size) > nb;
      elat = err ? 1 : w ? (crossing ? 3 : 2) : (crossing ? 4 : 3);
      v = '0;
      if (!err && w) begin
        for (int i = 0; i < size; i++) refm[d][(int'(ad) + i) & 255] = wd[8*i +: 8];
      end else if (!err) begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = refm[d][(int'(ad) + i) & 255];
        if (m[0] && v[8*size-1]) for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (d != 2) v[63:32] = '0;
      end
      check($sformatf("lat%0d m%0d w%0d @%0h", d, m, w, ad), 64'(lat[d]), 64'(elat));
      check($sformatf("nresp%0d", d), 64'(nresp[d]), 64'd1);
      check($sformatf("err%0d m%0d @%0h", d, m, ad), 64'(er[d]), 64'(err));
      check($sformatf("rdata%0d m%0d @%0h", d, m, ad), rd[d], v);
      check($sformatf("wren%0d", d), 64'(wr_seen[d]), 64'(!err && w));
      check($sformatf("ready_after%0d", d), 64'(rdy_after[d]), 64'd1);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_mode = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 64'(a_req_ready), 64'd1);
    check("rst_valid", 64'(a_resp_valid), 64'd0);
    check("rst_rdata", 64'(a_resp_rdata), 64'd0);
    check("rst_err", 64'(a_resp_err), 64'd0);
    check("rst_wren", 64'(a_mem_wren), 64'd0);
    check("rst_byteen", 64'(a_mem_byteen), 64'hF);
    check("rst_addr", 64'(a_mem_addr), 64'd0);
    check("rst_wdata", 64'(a_mem_wdata), 64'd0);
    check("rst_byteen64", 64'(c_mem_byteen), 64'hFF);

    for (int i = 0; i < 256; i++) poke(i, 8'($urandom));

    poke_bytes(16, 64'hDEADBEEF, 4);
    do_req(1'b0, MEM_MODE_WORD, 32'h10, '0);
    check("t1_addr", 64'(a_addr_c[1]), 64'd4);
    check("t1_rdata", rd[0], 64'hDEADBEEF);

    poke_bytes(16, 64'h80FF0000, 4);
    do_req(1'b0, MEM_MODE_BYTE_SIGN, 32'h13, '0);
    check("t2_sign", rd[0], 64'hFFFFFF80);
    do_req(1'b0, MEM_MODE_BYTE, 32'h13, '0);
    check("t2_zero", rd[0], 64'h80);

    poke_bytes(12, 64'h44332211, 4);
    poke_bytes(16, 64'h88776655, 4);
    do_req(1'b0, MEM_MODE_WORD, 32'h0E, '0);
    check("t3_addr0", 64'(a_addr_c[1]), 64'd3);
    check("t3_addr1", 64'(a_addr_c[2]), 64'd4);
    check("t3_lat", 64'(lat[0]), 64'd4);
    check("t3_rdata", rd[0], 64'h66554433);

    do_req(1'b1, MEM_MODE_HWORD, 32'h07, 64'hABCD);
    check("t4_addr0", 64'(a_addr_c[1]), 64'd1);
    check("t4_be0", 64'(a_be_c[1]), 64'h8);
    check("t4_wd0", 64'(a_wd_c[1]), 64'hCD000000);
    check("t4_addr1", 64'(a_addr_c[2]), 64'd2);
    check("t4_be1", 64'(a_be_c[2]), 64'h1);
    check("t4_wd1", 64'(a_wd_c[2]), 64'h000000AB);
    check("t4_lat", 64'(lat[0]), 64'd3);

    do_req(1'b0, MEM_MODE_WORD, 32'h02, '0);
    check("t5_strict_err", 64'(er[1]), 64'd1);
    check("t5_strict_lat", 64'(lat[1]), 64'd1);
    do_req(1'b0, MEM_MODE_DWORD, 32'h0, '0);
    check("t5_dword32_err", 64'(er[0]), 64'd1);

    poke_bytes(8, 64'h0123456789ABCDEF, 8);
    do_req(1'b0, MEM_MODE_DWORD, 32'h08, '0);
    check("t6_rdata64", rd[2], 64'h0123456789ABCDEF);

    // Reset while a crossing store sits in its second RAM cycle.
    req_write = 1'b1; req_mode = MEM_MODE_HWORD; req_addr = 32'h07;
    req_wdata = 64'h1234; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t7_ready", 64'(a_req_ready), 64'd1);
    check("t7_ready64", 64'(c_req_ready), 64'd1);
    check("t7_wren", 64'(a_mem_wren), 64'd0);
    check("t7_wren64", 64'(c_mem_wren), 64'd0);
    check("t7_first_half", 64'(ram_a[7]), 64'h34);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_resp_valid || c_resp_valid) bad++;
      @(negedge clk);
    end
    check("t7_no_resp", 64'(bad), 64'd0);
    poke(7, 8'h5A);
    poke(8, 8'hA5);

    for (int t = 0; t < 250; t++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)),
             {32'($urandom), 32'($urandom)});
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram_a[i] !== refm[0][i]) bad++;
    check("mem_a", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram_b[i] !== refm[1][i]) bad++;
    check("mem_b", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram_c[i] !== refm[2][i]) bad++;
    check("mem_c", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
